// File: rtl/button_event_arbiter.sv
// Turns debounced button levels into press / release / long-press events and
// serialises them onto one valid/ready port, sharing channels round-robin.
module button_event_arbiter #(
  parameter int NUM_BUTTONS = 4,
  parameter int CH_WIDTH    = 2,
  parameter int HOLD_CYCLES = 50_000_000,
  parameter int CNT_WIDTH   = 26
) (
  input  logic                   clock,
  input  logic                   resetN,
  input  logic [NUM_BUTTONS-1:0] buttonsIn,
  output logic                   eventValid,
  input  logic                   eventReady,
  output logic [CH_WIDTH-1:0]    eventChannel,
  output logic [1:0]             eventType,
  output logic [NUM_BUTTONS-1:0] pendingMask,
  output logic                   overflow
);

  localparam logic [1:0]           EV_PRESS   = 2'b00;
  localparam logic [1:0]           EV_RELEASE = 2'b01;
  localparam logic [1:0]           EV_LONG    = 2'b10;
  localparam logic [CNT_WIDTH-1:0] HOLD_MAX   = CNT_WIDTH'(HOLD_CYCLES);
  localparam logic [CNT_WIDTH-1:0] LONG_PRE   = CNT_WIDTH'(HOLD_CYCLES - 2);
  localparam logic [CH_WIDTH-1:0]  LAST_CH    = CH_WIDTH'(NUM_BUTTONS - 1);

  typedef enum logic {S_IDLE, S_OFFER} state_t;

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (v >= HOLD_MAX) ? HOLD_MAX : v + 1'b1;
  endfunction

  state_t                 r_state;
  logic [NUM_BUTTONS-1:0] r_prev;
  logic [NUM_BUTTONS-1:0] r_pend_press;
  logic [NUM_BUTTONS-1:0] r_pend_long;
  logic [NUM_BUTTONS-1:0] r_pend_rel;
  logic [NUM_BUTTONS-1:0] r_mask;
  logic [CH_WIDTH-1:0]    r_rr;
  logic [CH_WIDTH-1:0]    r_ch;
  logic [1:0]             r_type;
  logic                   r_valid;
  logic                   r_ovf;

  logic [NUM_BUTTONS-1:0] w_rise;
  logic [NUM_BUTTONS-1:0] w_fall;
  logic [NUM_BUTTONS-1:0] w_long;
  logic [NUM_BUTTONS-1:0] w_pend_any;
  logic [NUM_BUTTONS-1:0] w_pick_oh;
  logic [NUM_BUTTONS-1:0] w_clr_press;
  logic [NUM_BUTTONS-1:0] w_clr_long;
  logic [NUM_BUTTONS-1:0] w_clr_rel;
  logic [NUM_BUTTONS-1:0] w_press_nxt;
  logic [NUM_BUTTONS-1:0] w_long_nxt;
  logic [NUM_BUTTONS-1:0] w_rel_nxt;
  logic                   w_found;
  logic                   w_take;
  logic                   w_drop;
  logic [CH_WIDTH-1:0]    w_pick;
  logic [1:0]             w_type;

  assign w_rise     = buttonsIn & ~r_prev;
  assign w_fall     = ~buttonsIn & r_prev;
  assign w_pend_any = r_pend_press | r_pend_long | r_pend_rel;

  // Hold counter is one short of HOLD_CYCLES-1 here, so the long-press lands on the same edge.
  for (genvar g = 0; g < NUM_BUTTONS; g++) begin : g_hold
    logic [CNT_WIDTH-1:0] r_cnt;

    assign w_long[g] = buttonsIn[g] & ~w_rise[g] & (r_cnt == LONG_PRE);

    always_ff @(posedge clock or negedge resetN) begin
      if (!resetN) begin
        r_cnt <= '0;
      end else if (!buttonsIn[g] || w_rise[g]) begin
        r_cnt <= '0;
      end else begin
        r_cnt <= sat_inc(r_cnt);
      end
    end
  end

  always_comb begin
    w_found = 1'b0;
    w_pick  = '0;
    for (int k = 0; k < NUM_BUTTONS; k++) begin
      int idx;
      idx = int'(r_rr) + k;
      if (idx >= NUM_BUTTONS) idx = idx - NUM_BUTTONS;
      if (!w_found && ((w_pend_any >> idx) & NUM_BUTTONS'(1)) != '0) begin
        w_found = 1'b1;
        w_pick  = CH_WIDTH'(idx);
      end
    end
  end

  assign w_pick_oh = NUM_BUTTONS'(1) << w_pick;

  always_comb begin
    if ((r_pend_press & w_pick_oh) != '0) begin
      w_type = EV_PRESS;
    end else if ((r_pend_long & w_pick_oh) != '0) begin
      w_type = EV_LONG;
    end else begin
      w_type = EV_RELEASE;
    end
  end

  assign w_take      = (r_state == S_IDLE) && w_found;
  assign w_clr_press = (w_take && w_type == EV_PRESS)   ? w_pick_oh : '0;
  assign w_clr_long  = (w_take && w_type == EV_LONG)    ? w_pick_oh : '0;
  assign w_clr_rel   = (w_take && w_type == EV_RELEASE) ? w_pick_oh : '0;

  // New events are ORed in after the clear, so a same-cycle set survives the grant.
  assign w_press_nxt = (r_pend_press & ~w_clr_press) | w_rise;
  assign w_long_nxt  = (r_pend_long  & ~w_clr_long)  | w_long;
  assign w_rel_nxt   = (r_pend_rel   & ~w_clr_rel)   | w_fall;

  assign w_drop = |((r_pend_press & ~w_clr_press & w_rise) |
                    (r_pend_long  & ~w_clr_long  & w_long) |
                    (r_pend_rel   & ~w_clr_rel   & w_fall));

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      r_prev       <= '0;
      r_pend_press <= '0;
      r_pend_long  <= '0;
      r_pend_rel   <= '0;
      r_mask       <= '0;
      r_ovf        <= 1'b0;
    end else begin
      r_prev       <= buttonsIn;
      r_pend_press <= w_press_nxt;
      r_pend_long  <= w_long_nxt;
      r_pend_rel   <= w_rel_nxt;
      r_mask       <= w_press_nxt | w_long_nxt | w_rel_nxt;
      r_ovf        <= r_ovf | w_drop;
    end
  end

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      r_state <= S_IDLE;
      r_rr    <= '0;
      r_ch    <= '0;
      r_type  <= EV_PRESS;
      r_valid <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_found) begin
            r_ch    <= w_pick;
            r_type  <= w_type;
            r_valid <= 1'b1;
            r_state <= S_OFFER;
          end
        end
        S_OFFER: begin
          if (eventReady) begin
            r_valid <= 1'b0;
            r_rr    <= (r_ch == LAST_CH) ? '0 : r_ch + 1'b1;
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign eventValid   = r_valid;
  assign eventChannel = r_ch;
  assign eventType    = r_type;
  assign pendingMask  = r_mask;
  assign overflow     = r_ovf;

endmodule
